// File: rtl/pdm_frame_packer.sv
// pdm_frame_packer
//   Packs the 8 channel words of each PDM decoder sample strobe into one frame
//   (ch1 first), writes whole frames into a 33-bit {last, data} word FIFO and
//   streams the FIFO out over AXI4-Stream with tlast closing every
//   FRAMES_PER_PKT frames. A frame is either written completely or dropped.
//
// Ports
//   clk_240M       system clock
//   rstn           asynchronous active-low reset
//   en             capture enable, only acted on at packet boundaries
//   sample_strb    one-cycle strobe, data1..data8 valid
//   data1..data8   channel samples
//   m_axis_*       AXI4-Stream master (tdata / tvalid / tready / tlast)
//   frame_drop     one-cycle pulse per dropped frame
//   ovf_cnt        saturating dropped-frame counter
//   fifo_level     words currently held in the FIFO
module pdm_frame_packer #(
    parameter int unsigned FRAMES_PER_PKT = 64,
    parameter int unsigned FIFO_AW        = 9,
    parameter int unsigned OVF_W          = 16
) (
    input  logic               clk_240M,
    input  logic               rstn,
    input  logic               en,
    input  logic               sample_strb,
    input  logic [31:0]        data1,
    input  logic [31:0]        data2,
    input  logic [31:0]        data3,
    input  logic [31:0]        data4,
    input  logic [31:0]        data5,
    input  logic [31:0]        data6,
    input  logic [31:0]        data7,
    input  logic [31:0]        data8,
    output logic [31:0]        m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               frame_drop,
    output logic [OVF_W-1:0]   ovf_cnt,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned LVL_W = FIFO_AW + 1;
    localparam int unsigned FIP_W = (FRAMES_PER_PKT > 1) ? $clog2(FRAMES_PER_PKT) : 1;

    typedef enum logic { STOPPED, RUNNING } sess_t;
    typedef enum logic { IDLE, WR } seq_t;

    sess_t              sess;
    seq_t               seq;
    logic [2:0]         wr_idx;
    logic [31:0]        shadow [8];
    logic [FIP_W-1:0]   frame_in_pkt;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [32:0]        mem [DEPTH];

    logic        strb_active;
    logic        room;
    logic        accept;
    logic        drop;
    logic        last_frame;
    logic        fifo_wr;
    logic        fifo_rd;
    logic [32:0] wr_word;

    always_comb begin
        strb_active = sample_strb && ((sess == RUNNING) || en);
        // Room for a whole frame judged on the strobe-cycle level only.
        room        = (fifo_level <= LVL_W'(DEPTH - 8));
        accept      = strb_active && (seq == IDLE) && room;
        drop        = strb_active && !accept;
        last_frame  = (frame_in_pkt == FIP_W'(FRAMES_PER_PKT - 1));
        fifo_wr     = (seq == WR);
        fifo_rd     = m_axis_tvalid && m_axis_tready;
        wr_word     = {last_frame && (wr_idx == 3'd7), shadow[wr_idx]};
    end

    // First-word-fall-through output straight from the head entry; gated so
    // outputs read zero whenever the FIFO is empty (including after reset).
    assign m_axis_tvalid = (fifo_level != '0);
    assign {m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_240M) begin
        if (fifo_wr)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk_240M or negedge rstn) begin
        if (!rstn) begin
            sess         <= STOPPED;
            seq          <= IDLE;
            wr_idx       <= '0;
            frame_in_pkt <= '0;
            frame_drop   <= 1'b0;
            ovf_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            for (int unsigned i = 0; i < 8; i++)
                shadow[i] <= '0;
        end else begin
            frame_drop <= drop;
            if (drop && (ovf_cnt != '1))
                ovf_cnt <= ovf_cnt + 1'b1;

            case (seq)
                IDLE: begin
                    if (accept) begin
                        shadow[0] <= data1;
                        shadow[1] <= data2;
                        shadow[2] <= data3;
                        shadow[3] <= data4;
                        shadow[4] <= data5;
                        shadow[5] <= data6;
                        shadow[6] <= data7;
                        shadow[7] <= data8;
                        wr_idx    <= '0;
                        seq       <= WR;
                        // Leaving STOPPED always happens with frame_in_pkt = 0,
                        // so the accepted frame opens a fresh packet.
                        sess      <= RUNNING;
                    end
                end
                WR: begin
                    wr_idx <= wr_idx + 1'b1;
                    if (wr_idx == 3'd7) begin
                        seq          <= IDLE;
                        frame_in_pkt <= last_frame ? '0 : frame_in_pkt + 1'b1;
                        if (last_frame && !en)
                            sess <= STOPPED;
                    end
                end
                default: seq <= IDLE;
            endcase

            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule
